// File: rtl/vfpu_stream_ctrl.sv
// -----------------------------------------------------------------------------
// vfpu_stream_ctrl
//
// Job sequencer for the vector FPU streamer. One job is an NB_OPERANDS-source,
// one-sink add. On start the descriptor is latched and the address-generator
// fields for all streams are driven from it. A one-cycle stream_clear_o flushes
// the streamer FIFOs. req_start is fired on every stream together once all of
// them report ready_start. Completion is signalled after each stream's done
// pulse has been seen.
//
// Optional watchdog: define VFPU_STREAM_CTRL_TIMEOUT_EN to bound the RUN state
// to TIMEOUT_CYCLES cycles. On expiry the job is aborted: err_o is set,
// the FIFOs are cleared and done_o still pulses.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous soft clear (dominates everything)
//   start_i                job start pulse (ignored while busy_o)
//   len_i, stride_i        job length in words, byte stride
//   src_base_i             packed source bases, operand k at [32k+31:32k]
//   sink_base_i            result base address
//   src_/sink_ready_start_i, src_/sink_done_i   streamer flags
//   src_/sink_req_start_o  streamer start requests
//   src_/sink_base_addr_o, trans_size_o, line_stride_o   addressgen fields
//   stream_clear_o         FIFO clear pulse
//   busy_o, done_o, err_o  job status
// -----------------------------------------------------------------------------
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_IDLE    | no job, waiting for start_i
// ST_CLR     | descriptor latched, stream_clear_o high for this cycle
// ST_WAIT_RDY| waiting for all ready_start; req_start fires in the exit cycle
// ST_RUN     | collecting per-stream done pulses (watchdog runs if enabled)
// ST_FINISH  | done_o high for this cycle, back to idle next
//
module vfpu_stream_ctrl #(
    parameter int NB_OPERANDS    = 2,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    input  logic [15:0]               stride_i,
    input  logic [NB_OPERANDS*32-1:0] src_base_i,
    input  logic [31:0]               sink_base_i,
    input  logic [NB_OPERANDS-1:0]    src_ready_start_i,
    input  logic [NB_OPERANDS-1:0]    src_done_i,
    input  logic                      sink_ready_start_i,
    input  logic                      sink_done_i,
    output logic [NB_OPERANDS-1:0]    src_req_start_o,
    output logic [NB_OPERANDS*32-1:0] src_base_addr_o,
    output logic                      sink_req_start_o,
    output logic [31:0]               sink_base_addr_o,
    output logic [LEN_WIDTH-1:0]      trans_size_o,
    output logic [15:0]               line_stride_o,
    output logic                      stream_clear_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int NB_STREAMS = NB_OPERANDS + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WAIT_RDY,
        ST_RUN,
        ST_FINISH
    } state_e;

    state_e                      state_q, state_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [15:0]                 stride_q, stride_d;
    logic [NB_OPERANDS*32-1:0]   src_base_q, src_base_d;
    logic [31:0]                 sink_base_q, sink_base_d;
    logic [NB_STREAMS-1:0]       done_mask_q, done_mask_d;
    logic                        stream_clear_q, stream_clear_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic                        all_ready;
    logic                        fire;
    logic [NB_STREAMS-1:0]       done_in;
    logic [NB_STREAMS-1:0]       done_mask_nxt;

`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES);
    logic [31:0]                 tmo_cnt_q, tmo_cnt_d;
`else
    // The limit only matters with the watchdog built in.
    logic                        unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    assign all_ready = (&src_ready_start_i) & sink_ready_start_i;
    assign done_in   = {sink_done_i, src_done_i};

    // req_start follows ready_start combinationally so the request lands in
    // the same cycle the last stream becomes ready, as the handshake expects.
    assign fire = (state_q == ST_WAIT_RDY) && all_ready;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        stride_d       = stride_q;
        src_base_d     = src_base_q;
        sink_base_d    = sink_base_q;
        done_mask_d    = done_mask_q;
        stream_clear_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_d          = err_q;
        done_mask_nxt  = done_mask_q | done_in;
`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d       = len_i;
                    stride_d    = stride_i;
                    src_base_d  = src_base_i;
                    sink_base_d = sink_base_i;
                    busy_d      = 1'b1;
                    done_mask_d = '0;
                    if (len_i == '0) begin
                        // Empty job: report it as an error and complete
                        // without touching the streamer.
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = ST_CLR;
                        stream_clear_d = 1'b1;
                    end
                end
            end

            ST_CLR: begin
                state_d = ST_WAIT_RDY;
            end

            ST_WAIT_RDY: begin
                if (all_ready) begin
                    // Done pulses coinciding with req_start still count.
                    if (&done_mask_nxt) begin
                        state_d     = ST_FINISH;
                        done_d      = 1'b1;
                        done_mask_d = '0;
                    end else begin
                        state_d     = ST_RUN;
                        done_mask_d = done_mask_nxt;
                    end
`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
                    tmo_cnt_d = TMO_LOAD;
`endif
                end
            end

            ST_RUN: begin
                if (&done_mask_nxt) begin
                    state_d     = ST_FINISH;
                    done_d      = 1'b1;
                    done_mask_d = '0;
                end
`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    state_d        = ST_FINISH;
                    done_d         = 1'b1;
                    err_d          = 1'b1;
                    stream_clear_d = 1'b1;
                    done_mask_d    = '0;
                end else begin
                    done_mask_d = done_mask_nxt;
                    tmo_cnt_d   = tmo_cnt_q - 32'd1;
                end
`else
                else begin
                    done_mask_d = done_mask_nxt;
                end
`endif
            end

            ST_FINISH: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                done_mask_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (clear_i) begin
            state_d        = ST_IDLE;
            len_d          = '0;
            stride_d       = '0;
            src_base_d     = '0;
            sink_base_d    = '0;
            done_mask_d    = '0;
            stream_clear_d = 1'b0;
            busy_d         = 1'b0;
            done_d         = 1'b0;
            err_d          = 1'b0;
`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
            tmo_cnt_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            stride_q       <= '0;
            src_base_q     <= '0;
            sink_base_q    <= '0;
            done_mask_q    <= '0;
            stream_clear_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
            tmo_cnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            stride_q       <= stride_d;
            src_base_q     <= src_base_d;
            sink_base_q    <= sink_base_d;
            done_mask_q    <= done_mask_d;
            stream_clear_q <= stream_clear_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
`endif
        end
    end

    assign src_req_start_o  = {NB_OPERANDS{fire}};
    assign sink_req_start_o = fire;
    assign src_base_addr_o  = src_base_q;
    assign sink_base_addr_o = sink_base_q;
    assign trans_size_o     = len_q;
    assign line_stride_o    = stride_q;
    assign stream_clear_o   = stream_clear_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_vfpu_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vfpu_stream_ctrl
//
// Directed bench for vfpu_stream_ctrl. A job-level model (acceptance cycle,
// request cycle, set of streams seen done, finish cycle) predicts every output
// each cycle; hand-computed literal checks pin the key cycles of each scenario.
// With VFPU_STREAM_CTRL_TIMEOUT_EN defined the watchdog scenario is added.
// -----------------------------------------------------------------------------
module tb_vfpu_stream_ctrl;

`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
    localparam int  TB_TMO = 100;
    localparam bit  TMO_EN = 1'b1;
`else
    localparam int  TB_TMO = 65535;
    localparam bit  TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic [15:0] stride = '0;
    logic [63:0] src_base = '0;
    logic [31:0] sink_base = '0;
    logic [1:0]  src_rdy = '0;
    logic [1:0]  src_done = '0;
    logic        sink_rdy = 1'b0;
    logic        sink_done = 1'b0;

    logic [1:0]  src_req;
    logic [63:0] src_addr;
    logic        sink_req;
    logic [31:0] sink_addr;
    logic [15:0] trans_size;
    logic [15:0] line_stride;
    logic        stream_clear;
    logic        busy;
    logic        done;
    logic        err;

    vfpu_stream_ctrl #(
        .NB_OPERANDS   (2),
        .LEN_WIDTH     (16),
        .TIMEOUT_CYCLES(TB_TMO)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .clear_i           (clear),
        .start_i           (start),
        .len_i             (len),
        .stride_i          (stride),
        .src_base_i        (src_base),
        .sink_base_i       (sink_base),
        .src_ready_start_i (src_rdy),
        .src_done_i        (src_done),
        .sink_ready_start_i(sink_rdy),
        .sink_done_i       (sink_done),
        .src_req_start_o   (src_req),
        .src_base_addr_o   (src_addr),
        .sink_req_start_o  (sink_req),
        .sink_base_addr_o  (sink_addr),
        .trans_size_o      (trans_size),
        .line_stride_o     (line_stride),
        .stream_clear_o    (stream_clear),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- job-level model ----------------
    bit          m_active, m_zero, m_err, m_tmo;
    int          m_tacc, m_req, m_fin;
    bit [2:0]    m_seen;
    logic [15:0] m_len, m_stride;
    logic [63:0] m_src;
    logic [31:0] m_sink;

    initial begin
        m_active = 0; m_zero = 0; m_err = 0; m_tmo = 0;
        m_tacc = -10; m_req = -1; m_fin = -1; m_seen = '0;
        m_len = '0; m_stride = '0; m_src = '0; m_sink = '0;
    end

    function automatic bit exp_req();
        return m_active && !m_zero && (m_req < 0) && (m_fin < 0) &&
               (cyc >= m_tacc + 2) && (&src_rdy) && sink_rdy;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            m_active = 0; m_zero = 0; m_err = 0; m_tmo = 0;
            m_tacc = -10; m_req = -1; m_fin = -1; m_seen = '0;
            m_len = '0; m_stride = '0; m_src = '0; m_sink = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_tacc   = cyc;
                m_zero   = (len == 16'd0);
                m_req    = -1;
                m_seen   = '0;
                m_tmo    = 0;
                m_len    = len;
                m_stride = stride;
                m_src    = src_base;
                m_sink   = sink_base;
                m_fin    = m_zero ? cyc + 1 : -1;
                if (m_zero) m_err = 1;
            end
        end else if (cyc == m_fin) begin
            m_active = 0;
        end else begin
            if (exp_req()) m_req = cyc;
            if (m_req >= 0) begin
                m_seen = m_seen | {sink_done, src_done};
                if (&m_seen) begin
                    m_fin = cyc + 1;
                end else if (TMO_EN && cyc == m_req + 1 + TB_TMO) begin
                    m_fin = cyc + 1;
                    m_tmo = 1;
                    m_err = 1;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic r;
        r = exp_req();
        chk("m_src_req",   src_req, {r, r});
        chk("m_sink_req",  sink_req, r);
        chk("m_busy",      busy, m_active);
        chk("m_clear",     stream_clear,
            m_active && ((!m_zero && cyc == m_tacc + 1) || (m_tmo && cyc == m_fin)));
        chk("m_done",      done, m_active && cyc == m_fin);
        chk("m_err",       err, m_err);
        chk("m_trans",     trans_size, m_len);
        chk("m_stride",    line_stride, m_stride);
        chk("m_src_addr",  src_addr, m_src);
        chk("m_sink_addr", sink_addr, m_sink);
    end

    // ---------------- stimulus ----------------
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dones(input logic [2:0] d);
        src_done  = d[1:0];
        sink_done = d[2];
    endtask

    initial begin
        int c;

        // reset
        step_to(2);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        step_to(3);
        rst_n = 1'b1;
        step_to(4);
        @(negedge clk);
        chk("rst_err", err, 1'b0);
        chk("rst_trans", trans_size, 16'd0);

        // basic job
        step_to(6);
        c = cyc;
        src_rdy = 2'b11; sink_rdy = 1'b1;
        start = 1'b1; len = 16'd16; stride = 16'd4;
        src_base = {32'h0000_2000, 32'h0000_1000}; sink_base = 32'h0000_3000;
        step_to(c + 1);
        start = 1'b0;
        @(negedge clk);
        chk("basic_clr", stream_clear, 1'b1);
        chk("basic_busy", busy, 1'b1);
        step_to(c + 2);
        @(negedge clk);
        chk("basic_req", {sink_req, src_req}, 3'b111);
        chk("basic_trans", trans_size, 16'd16);
        chk("basic_src", src_addr, 64'h0000_2000_0000_1000);
        chk("basic_sink", sink_addr, 32'h0000_3000);
        step_to(c + 30); set_dones(3'b001);
        step_to(c + 31); set_dones(3'b010);
        step_to(c + 32); set_dones(3'b000);
        step_to(c + 40); set_dones(3'b100);
        @(negedge clk);
        chk("basic_nodone", done, 1'b0);
        step_to(c + 41); set_dones(3'b000);
        @(negedge clk);
        chk("basic_done", done, 1'b1);
        step_to(c + 42);
        @(negedge clk);
        chk("basic_idle", busy, 1'b0);

        // late sink ready
        step_to(c + 45);
        c = cyc;
        sink_rdy = 1'b0;
        start = 1'b1; len = 16'd8; stride = 16'd12;
        src_base = {32'hA000_0040, 32'hB000_0080}; sink_base = 32'hC000_0000;
        step_to(c + 1); start = 1'b0;
        step_to(c + 4);
        @(negedge clk);
        chk("late_noreq", {sink_req, src_req}, 3'b000);
        step_to(c + 7); sink_rdy = 1'b1;
        @(negedge clk);
        chk("late_req", {sink_req, src_req}, 3'b111);
        step_to(c + 8);
        @(negedge clk);
        chk("late_req_once", {sink_req, src_req}, 3'b000);
        step_to(c + 10); set_dones(3'b111);
        step_to(c + 11); set_dones(3'b000);
        @(negedge clk);
        chk("late_done", done, 1'b1);

        // simultaneous dones, start during RUN ignored
        step_to(c + 14);
        c = cyc;
        start = 1'b1; len = 16'd9; stride = 16'd8;
        src_base = {32'h0000_0100, 32'h0000_0200}; sink_base = 32'h0000_0300;
        step_to(c + 1); start = 1'b0;
        step_to(c + 5); start = 1'b1; len = 16'd7;
        step_to(c + 6); start = 1'b0;
        @(negedge clk);
        chk("sim_noclr", stream_clear, 1'b0);
        chk("sim_trans_kept", trans_size, 16'd9);
        step_to(c + 8); set_dones(3'b111);
        step_to(c + 9); set_dones(3'b000);
        @(negedge clk);
        chk("sim_done", done, 1'b1);
        step_to(c + 10);
        @(negedge clk);
        chk("sim_done_once", done, 1'b0);
        chk("sim_idle", busy, 1'b0);

        // zero length
        step_to(c + 12);
        c = cyc;
        start = 1'b1; len = 16'd0; stride = 16'd4;
        step_to(c + 1); start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1'b1);
        chk("zero_err", err, 1'b1);
        chk("zero_noclr", stream_clear, 1'b0);
        chk("zero_noreq", {sink_req, src_req}, 3'b000);
        step_to(c + 3);
        start = 1'b1; len = 16'd5; stride = 16'd2;
        step_to(c + 4); start = 1'b0;
        step_to(c + 10); set_dones(3'b111);
        step_to(c + 11); set_dones(3'b000);
        @(negedge clk);
        chk("zero_next_done", done, 1'b1);
        chk("zero_err_sticky", err, 1'b1);
        step_to(c + 13); clear = 1'b1;
        step_to(c + 14); clear = 1'b0;
        @(negedge clk);
        chk("zero_err_cleared", err, 1'b0);

        // clear in the middle of a job
        step_to(c + 16);
        c = cyc;
        start = 1'b1; len = 16'd12; stride = 16'd4;
        src_base = {32'h0001_0000, 32'h0002_0000}; sink_base = 32'h0003_0000;
        step_to(c + 1); start = 1'b0;
        step_to(c + 6); clear = 1'b1;
        step_to(c + 7); clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 1'b0);
        chk("clr_nodone", done, 1'b0);
        chk("clr_trans", trans_size, 16'd0);
        step_to(c + 8); set_dones(3'b111);
        step_to(c + 9); set_dones(3'b000);
        step_to(c + 10);
        start = 1'b1; len = 16'd3;
        step_to(c + 11); start = 1'b0;
        step_to(c + 15); set_dones(3'b111);
        step_to(c + 16); set_dones(3'b000);
        @(negedge clk);
        chk("clr_next_done", done, 1'b1);

`ifdef VFPU_STREAM_CTRL_TIMEOUT_EN
        // watchdog: sink never reports done
        step_to(c + 20);
        c = cyc;
        start = 1'b1; len = 16'd4; stride = 16'd4;
        step_to(c + 1); start = 1'b0;
        step_to(c + 5); set_dones(3'b011);
        step_to(c + 6); set_dones(3'b000);
        step_to(c + 103);
        @(negedge clk);
        chk("tmo_nodone", done, 1'b0);
        step_to(c + 104);
        @(negedge clk);
        chk("tmo_err", err, 1'b1);
        chk("tmo_clr", stream_clear, 1'b1);
        chk("tmo_done", done, 1'b1);
        step_to(c + 105);
        @(negedge clk);
        chk("tmo_idle", busy, 1'b0);
`endif

        step_to(cyc + 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
